bos_cds_model: RTL

//  Loopback receiver for the CCD-mode stimulus stream: models the SBIS BOS analog front end in FPGA fabric.

---
 rtl/bos_cds_model.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/bos_cds_model.sv
// Correlated-double-sampling receiver model: samples dac_d on shp/shd rises, applies the OB clamp and pedestal, and emits saturated codes.
// Latency: q_valid is high 2 cycles after the FSM sees the shd rise. There is no backpressure; one strobe is produced per accepted pixel.
module bos_cds_model #(
    parameter int DAC_W    = 14,
    parameter int OUT_W    = 12,
    parameter int OB_LOG2  = 3,
    parameter int PEDESTAL = 64
) (
    input  logic               sys_clk,
    input  logic               aclr,
    input  logic               enable,
    input  logic [DAC_W-1:0]   dac_d,
    input  logic               shp_fpga,
    input  logic               shd_fpga,
    input  logic               hd_fpga,
    input  logic               vd_fpga,
    input  logic               clpdm_fpga,
    output logic [OUT_W-1:0]   q_out,
    output logic               q_valid,
    output logic [DAC_W-2:0]   ob_level,
    output logic [11:0]        pix_cnt,
    output logic [11:0]        line_len,
    output logic [11:0]        line_cnt,
    output logic               seq_err,
    output logic               ob_short
);
    localparam int SD_W  = DAC_W - 1;
    localparam int ACC_W = SD_W + OB_LOG2;
    localparam logic [OB_LOG2:0] OB_FULL = (OB_LOG2 + 1)'(2 ** OB_LOG2);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_RST, S_WAIT_VID} state_t;

    state_t             r_state, w_next;
    logic [DAC_W-1:0]   r_dac, r_rst_smp;
    logic               r_shp, r_shd, r_hd, r_vd, r_clp;
    logic               r_shp_p, r_shd_p, r_hd_p, r_vd_p, r_clp_p;
    logic               w_shp_rise, w_shd_rise, w_hd_rise, w_vd_rise, w_clp_fall;
    logic               w_cap_rst, w_cap_vid, w_err;
    logic [DAC_W:0]     w_diff;
    logic [SD_W-1:0]    w_sd, r_sd;
    logic               r_s1_vld;
    logic [15:0]        w_code;
    logic [OUT_W-1:0]   w_code_sat, r_q_out;
    logic               r_q_valid;
    logic [ACC_W-1:0]   r_ob_acc;
    logic [OB_LOG2:0]   r_ob_cnt;
    logic [SD_W-1:0]    r_ob_level;
    logic [11:0]        r_pix_cnt, r_line_len, r_line_cnt;
    logic               r_seq_err, r_ob_short;

    // Clamp history resets low so that no spurious clamp-window end is seen after reset.
    always_ff @(posedge sys_clk or posedge aclr) begin
        if (aclr) begin
            r_dac   <= '0;
            {r_shp, r_shd, r_hd, r_vd, r_clp} <= '0;
            {r_shp_p, r_shd_p, r_hd_p, r_vd_p} <= '1;
            r_clp_p <= 1'b0;
        end else begin
            r_dac   <= dac_d;
            {r_shp, r_shd, r_hd, r_vd, r_clp} <= {shp_fpga, shd_fpga, hd_fpga, vd_fpga, clpdm_fpga};
            {r_shp_p, r_shd_p, r_hd_p, r_vd_p, r_clp_p} <= {r_shp, r_shd, r_hd, r_vd, r_clp};
        end
    end

    assign w_shp_rise = r_shp & ~r_shp_p;
    assign w_shd_rise = r_shd & ~r_shd_p;
    assign w_hd_rise  = r_hd & ~r_hd_p;
    assign w_vd_rise  = r_vd & ~r_vd_p;
    assign w_clp_fall = ~r_clp & r_clp_p;

    always_ff @(posedge sys_clk or posedge aclr) begin
        if (aclr) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_cap_rst = 1'b0;
        w_cap_vid = 1'b0;
        w_err     = 1'b0;
        if (!enable) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: w_next = S_WAIT_RST;
                S_WAIT_RST: begin
                    if (w_shd_rise) begin
                        w_err = 1'b1;
                    end else if (w_shp_rise) begin
                        w_cap_rst = 1'b1;
                        w_next    = S_WAIT_VID;
                    end
                end
                S_WAIT_VID: begin
                    if (w_shp_rise && w_shd_rise) begin
                        w_err = 1'b1;
                    end else if (w_shp_rise) begin
                        w_cap_rst = 1'b1;
                        w_err     = 1'b1;
                    end else if (w_shd_rise) begin
                        w_cap_vid = 1'b1;
                        w_next    = S_WAIT_RST;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Dropping the two low bits of the 15-bit difference is the arithmetic shift by 2.
    assign w_diff = {1'b0, r_rst_smp} - {1'b0, r_dac};
    assign w_sd   = w_diff[DAC_W:2];
    assign w_code = {{(16 - SD_W){r_sd[SD_W-1]}}, r_sd}
                  - {{(16 - SD_W){r_ob_level[SD_W-1]}}, r_ob_level}
                  + 16'(PEDESTAL);

    always_comb begin
        w_code_sat = w_code[OUT_W-1:0];
        if (w_code[15])             w_code_sat = '0;
        else if (|w_code[14:OUT_W]) w_code_sat = '1;
    end

    always_ff @(posedge sys_clk or posedge aclr) begin
        if (aclr) begin
            r_rst_smp <= '0;
            r_sd      <= '0;
            r_s1_vld  <= 1'b0;
            r_q_out   <= '0;
            r_q_valid <= 1'b0;
            r_seq_err <= 1'b0;
        end else begin
            if (w_cap_rst) r_rst_smp <= r_dac;
            if (w_cap_vid) r_sd <= w_sd;
            r_s1_vld  <= w_cap_vid;
            r_q_valid <= r_s1_vld;
            if (r_s1_vld) r_q_out <= w_code_sat;
            if (w_err) r_seq_err <= 1'b1;
        end
    end

    // Clamp pixels accumulate in stage 1 and are still output against the old black level.
    always_ff @(posedge sys_clk or posedge aclr) begin
        if (aclr) begin
            r_ob_acc   <= '0;
            r_ob_cnt   <= '0;
            r_ob_level <= '0;
            r_ob_short <= 1'b0;
        end else if (w_clp_fall) begin
            if (r_ob_cnt == OB_FULL) r_ob_level <= r_ob_acc[ACC_W-1:OB_LOG2];
            else                     r_ob_short <= 1'b1;
            r_ob_acc <= '0;
            r_ob_cnt <= '0;
        end else if (r_s1_vld && r_clp && r_ob_cnt < OB_FULL) begin
            r_ob_acc <= r_ob_acc + {{OB_LOG2{r_sd[SD_W-1]}}, r_sd};
            r_ob_cnt <= r_ob_cnt + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge aclr) begin
        if (aclr) begin
            r_pix_cnt  <= '0;
            r_line_len <= '0;
            r_line_cnt <= '0;
        end else begin
            if (w_hd_rise) begin
                r_line_len <= r_pix_cnt;
                r_pix_cnt  <= r_q_valid ? 12'd1 : 12'd0;
            end else if (r_q_valid && r_pix_cnt != 12'hFFF) begin
                r_pix_cnt <= r_pix_cnt + 12'd1;
            end
            if (w_vd_rise)
                r_line_cnt <= w_hd_rise ? 12'd1 : 12'd0;
            else if (w_hd_rise && r_line_cnt != 12'hFFF)
                r_line_cnt <= r_line_cnt + 12'd1;
        end
    end

    assign q_out    = r_q_out;
    assign q_valid  = r_q_valid;
    assign ob_level = r_ob_level;
    assign pix_cnt  = r_pix_cnt;
    assign line_len = r_line_len;
    assign line_cnt = r_line_cnt;
    assign seq_err  = r_seq_err;
    assign ob_short = r_ob_short;
endmodule
